// File: rtl/serial_frame_tx.sv
// Parallel-to-serial framed transmitter: start bit, LSB-first data, optional even
// parity and 1-2 stop bits, one bit per bit_en strobe, idle-high line.
module serial_frame_tx #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned PARITY_EN = 1,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic              CLK,
    input  logic              RSTB,
    input  logic              bit_en,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              sdo,
    output logic              busy,
    output logic              frame_done
);

    // One counter serves both the data-bit index and the stop-bit count.
    localparam int unsigned CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_shreg;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_parity;
    logic                r_sdo;
    logic                r_busy;
    logic                r_frame_done;

    state_t              w_state_nxt;
    logic [DATA_W-1:0]   w_shreg_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                w_parity_nxt;
    logic                w_sdo_nxt;
    logic                w_busy_nxt;
    logic                w_frame_done_nxt;
    logic [DATA_W-1:0]   w_shift;

    assign w_shift = r_shreg >> 1;

    always_comb begin
        // NOTE: every next value is defaulted first so no path through the case infers a latch.
        w_state_nxt      = r_state;
        w_shreg_nxt      = r_shreg;
        w_cnt_nxt        = r_cnt;
        w_parity_nxt     = r_parity;
        w_sdo_nxt        = r_sdo;
        w_busy_nxt       = r_busy;
        w_frame_done_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_sdo_nxt  = 1'b1;
                w_busy_nxt = 1'b0;
                // Acceptance does not wait for bit_en; parity is fixed from the captured word.
                if (tx_valid) begin
                    w_state_nxt  = S_START;
                    w_shreg_nxt  = tx_data;
                    w_parity_nxt = ^tx_data;
                    w_cnt_nxt    = '0;
                    w_sdo_nxt    = 1'b0;
                    w_busy_nxt   = 1'b1;
                end
            end

            S_START: begin
                if (bit_en) begin
                    w_state_nxt = S_DATA;
                    w_sdo_nxt   = r_shreg[0];
                    w_cnt_nxt   = '0;
                end
            end

            S_DATA: begin
                if (bit_en) begin
                    w_shreg_nxt = w_shift;
                    w_cnt_nxt   = r_cnt + 1'b1;
                    w_sdo_nxt   = w_shift[0];
                    if (r_cnt == LAST_DATA) begin
                        w_cnt_nxt = '0;
                        if (PARITY_EN != 0) begin
                            w_state_nxt = S_PARITY;
                            w_sdo_nxt   = r_parity;
                        end else begin
                            w_state_nxt = S_STOP;
                            w_sdo_nxt   = 1'b1;
                        end
                    end
                end
            end

            S_PARITY: begin
                if (bit_en) begin
                    w_state_nxt = S_STOP;
                    w_sdo_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                end
            end

            S_STOP: begin
                w_sdo_nxt = 1'b1;
                if (bit_en) begin
                    if (r_cnt == LAST_STOP) begin
                        w_state_nxt      = S_IDLE;
                        w_busy_nxt       = 1'b0;
                        w_frame_done_nxt = 1'b1;
                        w_cnt_nxt        = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_sdo_nxt   = 1'b1;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            // NOTE: the shift register and counter are reset too, so every flop is a plain async-reset cell.
            r_state      <= S_IDLE;
            r_shreg      <= '0;
            r_cnt        <= '0;
            r_parity     <= 1'b0;
            r_sdo        <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the same pre-edge values.
            r_state      <= w_state_nxt;
            r_shreg      <= w_shreg_nxt;
            r_cnt        <= w_cnt_nxt;
            r_parity     <= w_parity_nxt;
            r_sdo        <= w_sdo_nxt;
            r_busy       <= w_busy_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    assign tx_ready   = (r_state == S_IDLE);
    assign sdo        = r_sdo;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule
